// File: rtl/mul16_shift_add_if.sv
// Operand and product valid/ready bundle for the 16x16 shift-add multiplier.
interface mul16_shift_add_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/mul16_shift_add.sv
// Sequential unsigned 16x16 -> 32 shift-add multiplier built around one
// adder16 carry-lookahead adder; 16 iteration cycles per product.
module adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] sum,
  output logic        co
);
  logic [15:0] g;
  logic [15:0] pp;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g  = a & b;
  assign pp = a ^ b;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &pp[4*k +: 4];
      gg[k] = g[4*k+3]
            | (pp[4*k+3] & g[4*k+2])
            | (pp[4*k+3] & pp[4*k+2] & g[4*k+1])
            | (pp[4*k+3] & pp[4*k+2] & pp[4*k+1] & g[4*k]);
    end
    // Group carries are resolved in parallel, then rippled only within a nibble.
    gc[0] = ci;
    gc[1] = gg[0] | (gp[0] & ci);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & ci);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & ci);
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (pp[4*k+j-1] & c[4*k+j-1]);
      end
    end
  end

  assign sum = pp ^ c;
  assign co  = gc[4];
endmodule

module mul16_shift_add (
  input  logic              clk,
  input  logic              rst,
  mul16_shift_add_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] mcand;
  logic [15:0] hi;
  logic [15:0] lo;
  logic [3:0]  cnt;
  logic [15:0] sum;
  logic        co;
  logic        accept;

  // The adder sees only register outputs plus one mux, keeping the RUN path short.
  adder16 u_adder (
    .a   (hi),
    .b   (lo[0] ? mcand : 16'h0000),
    .ci  (1'b0),
    .sum (sum),
    .co  (co)
  );

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.p         = {hi, lo};
  assign accept        = bus.in_valid && bus.in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = RUN;
      RUN:     if (cnt == 4'd15)  state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // NOTE: the datapath is cleared on reset so an aborted product never shows on p.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand <= bus.a;
            hi    <= '0;
            lo    <= bus.b;
            cnt   <= '0;
          end
        end
        RUN: begin
          // Carry-out becomes the new top bit; the adder LSB shifts into lo.
          hi  <= {co, sum[15:1]};
          lo  <= {sum[0], lo[15:1]};
          cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul16_shift_add.sv
// Scoreboard bench for mul16_shift_add: directed scenarios plus random traffic.
module tb_mul16_shift_add;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] sb[$];

  mul16_shift_add_if bus ();

  mul16_shift_add dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands at a falling edge, wait (bounded) for in_ready, transfer on the rising edge.
  task automatic do_accept(input logic [15:0] x, input logic [15:0] y, input bit push);
    int n;
    n = 0;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk);
    if (push) sb.push_back(32'(x) * 32'(y));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
  endtask

  // Wait (bounded) for out_valid, stall for hold cycles, then take the product.
  task automatic collect(input int hold, output logic [31:0] got, output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1", bus.out_valid);
    end
    repeat (hold) begin
      @(posedge clk); @(negedge clk);
    end
    got = bus.p;
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_high_rst: got %b required 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid);
    end
    checks++;
    if (bus.p !== 32'h0) begin
      errors++; $display("FAIL reset_p: got %h required 00000000", bus.p);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_after: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] got, exp;
    int cyc;
    do_accept(16'd3, 16'd5, 1'b1);
    collect(0, got, cyc);
    exp = sb.pop_front();
    checks++;
    if (cyc !== 16) begin
      errors++; $display("FAIL basic_latency: got %0d required 16", cyc);
    end
    checks++;
    if (got !== exp || got !== 32'h0000000F) begin
      errors++; $display("FAIL basic_p: got %h required %h", got, exp);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_idle_after: in_ready=%b out_valid=%b required 1/0",
                         bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_products(input string name, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] got, exp;
    int cyc;
    do_accept(x, y, 1'b1);
    collect(0, got, cyc);
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s: %h*%h got %h required %h", name, x, y, got, exp);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got, exp, old;
    int cyc, n;
    do_accept(16'h0102, 16'h0304, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); @(negedge clk); n++;
    end
    old = bus.p;
    exp = sb.pop_front();
    checks++;
    if (old !== exp) begin
      errors++; $display("FAIL bp_first_p: got %h required %h", old, exp);
    end
    bus.a = 16'd7;
    bus.b = 16'd9;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.p !== exp || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: p=%h in_ready=%b out_valid=%b required %h/0/1",
                 i, bus.p, bus.in_ready, bus.out_valid, exp);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0",
                         bus.in_ready, bus.out_valid);
    end
    sb.push_back(32'd7 * 32'd9);
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_second_accept: in_ready=%b required 0", bus.in_ready);
    end
    collect(0, got, cyc);
    exp = sb.pop_front();
    checks++;
    if (got !== exp || got !== 32'h0000003F) begin
      errors++; $display("FAIL bp_second_p: got %h required %h", got, exp);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    do_accept(16'hAAAA, 16'h5555, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.p !== 32'h0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_state: p=%h out_valid=%b in_ready=%b required 0/0/0",
                         bus.p, bus.out_valid, bus.in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_in_ready: got %b required 1", bus.in_ready);
    end
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midrst_ghost: out_valid seen=%b required 0", seen);
    end
    test_products("midrst_next", 16'h1234, 16'h0010);
  endtask

  task automatic test_random();
    logic [31:0] got, exp;
    logic [15:0] x, y;
    int cyc;
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); @(negedge clk);
      end
      x = 16'($urandom);
      y = 16'($urandom);
      do_accept(x, y, 1'b1);
      collect($urandom_range(0, 3), got, cyc);
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random_%0d: %h*%h got %h required %h", i, x, y, got, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = 16'h0;
    bus.b = 16'h0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_products("carry_ffff", 16'hFFFF, 16'hFFFF);
    test_products("carry_8000", 16'h8000, 16'h0002);
    test_backpressure();
    test_reset_mid_run();
    test_products("edge_0_ffff", 16'h0000, 16'hFFFF);
    test_products("edge_ffff_0", 16'hFFFF, 16'h0000);
    test_products("edge_1_ffff", 16'h0001, 16'hFFFF);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
